// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetches and load/store
// requests onto a single byte-wide RAM port and reassembles fetched words.
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_asking,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic              flush,
    output logic [31:0]       ic_data,
    output logic              ic_ready,
    input  logic              lsb_valid,
    input  logic              lsb_we,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [1:0]        lsb_size,
    input  logic              lsb_signed,
    input  logic [31:0]       lsb_wdata,
    output logic [31:0]       lsb_rdata,
    output logic              lsb_done,
    output logic              lsb_busy,
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_dout,
    output logic              mem_wr,
    input  logic [7:0]        mem_din
);

    typedef enum logic [1:0] {IDLE, IFETCH, LOAD, STORE} state_t;

    state_t            state, state_nx;
    logic              ic_pend;
    logic [ADDR_W-1:0] ic_pend_addr;
    logic              lsb_pend;
    logic              lsb_we_q;
    logic [ADDR_W-1:0] lsb_addr_q;
    logic [1:0]        lsb_size_q;
    logic              lsb_signed_q;
    logic [31:0]       lsb_wdata_q;
    logic [ADDR_W-1:0] base;
    logic [2:0]        cnt;
    logic [2:0]        nbytes;
    logic [7:0]        b0, b1, b2;

    logic              lsb_cap, lsb_req, ic_req;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr, ic_req_addr;
    logic [1:0]        req_size;
    logic [31:0]       req_wdata;
    logic              acc_lsb, acc_ic, fin, abort, last;
    logic [31:0]       word_all, ld_word;

    function automatic logic [2:0] size_n(input logic [1:0] s);
        case (s)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // A pending LSB slot already holds busy high, so direct capture and
    // slot hit can never both be true.
    always_comb begin
        lsb_cap     = lsb_valid && !lsb_busy;
        lsb_req     = lsb_pend || lsb_cap;
        ic_req      = ic_asking || (ic_pend && !flush);
        ic_req_addr = ic_asking ? ic_addr : ic_pend_addr;
        req_we      = lsb_pend ? lsb_we_q    : lsb_we;
        req_addr    = lsb_pend ? lsb_addr_q  : lsb_addr;
        req_size    = lsb_pend ? lsb_size_q  : lsb_size;
        req_wdata   = lsb_pend ? lsb_wdata_q : lsb_wdata;
        last        = (cnt == nbytes);
        state_nx    = state;
        acc_lsb     = 1'b0;
        acc_ic      = 1'b0;
        fin         = 1'b0;
        abort       = 1'b0;
        unique case (state)
            IDLE: begin
                if (lsb_req) begin
                    acc_lsb  = 1'b1;
                    state_nx = req_we ? STORE : LOAD;
                end else if (ic_req) begin
                    acc_ic   = 1'b1;
                    state_nx = IFETCH;
                end
            end
            IFETCH: begin
                if (flush) begin
                    abort    = 1'b1;
                    state_nx = IDLE;
                end else if (last) begin
                    fin      = 1'b1;
                    state_nx = IDLE;
                end
            end
            LOAD, STORE: begin
                if (last) begin
                    fin      = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        word_all = {mem_din, b2, b1, b0};
        case (nbytes)
            3'd1:    ld_word = {{24{lsb_signed_q & mem_din[7]}}, mem_din};
            3'd2:    ld_word = {{16{lsb_signed_q & mem_din[7]}}, mem_din, b0};
            default: ld_word = word_all;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            ic_pend      <= 1'b0;
            ic_pend_addr <= '0;
            lsb_pend     <= 1'b0;
            lsb_we_q     <= 1'b0;
            lsb_addr_q   <= '0;
            lsb_size_q   <= 2'b00;
            lsb_signed_q <= 1'b0;
            lsb_wdata_q  <= '0;
            base         <= '0;
            cnt          <= 3'd0;
            nbytes       <= 3'd0;
            b0           <= 8'h00;
            b1           <= 8'h00;
            b2           <= 8'h00;
            ic_data      <= '0;
            ic_ready     <= 1'b0;
            lsb_rdata    <= '0;
            lsb_done     <= 1'b0;
            lsb_busy     <= 1'b0;
            mem_a        <= '0;
            mem_dout     <= 8'h00;
            mem_wr       <= 1'b0;
        end else begin
            state    <= state_nx;
            ic_ready <= 1'b0;
            lsb_done <= 1'b0;
            // Flush clears the slot before a same-edge request re-arms it.
            if (flush) ic_pend <= 1'b0;
            if (ic_asking) begin
                ic_pend      <= 1'b1;
                ic_pend_addr <= ic_addr;
            end
            if (acc_ic) ic_pend <= 1'b0;
            if (lsb_cap) begin
                lsb_pend     <= 1'b1;
                lsb_busy     <= 1'b1;
                lsb_we_q     <= lsb_we;
                lsb_addr_q   <= lsb_addr;
                lsb_size_q   <= lsb_size;
                lsb_signed_q <= lsb_signed;
                lsb_wdata_q  <= lsb_wdata;
            end
            if (acc_lsb) lsb_pend <= 1'b0;
            if (acc_lsb || acc_ic) begin
                base   <= acc_lsb ? req_addr : ic_req_addr;
                mem_a  <= acc_lsb ? req_addr : ic_req_addr;
                cnt    <= 3'd1;
                nbytes <= acc_lsb ? size_n(req_size) : 3'd4;
                if (acc_lsb && req_we) begin
                    mem_dout <= req_wdata[7:0];
                    mem_wr   <= 1'b1;
                end
            end else if (state != IDLE && !abort) begin
                if (state != STORE) begin
                    case (cnt)
                        3'd1:    b0 <= mem_din;
                        3'd2:    b1 <= mem_din;
                        3'd3:    b2 <= mem_din;
                        default: ;
                    endcase
                end
                if (!last) begin
                    mem_a <= base + ADDR_W'(cnt);
                    cnt   <= cnt + 3'd1;
                    case (cnt)
                        3'd1:    mem_dout <= lsb_wdata_q[15:8];
                        3'd2:    mem_dout <= lsb_wdata_q[23:16];
                        default: mem_dout <= lsb_wdata_q[31:24];
                    endcase
                end
            end
            if (fin) begin
                unique case (state)
                    IFETCH: begin
                        ic_ready <= 1'b1;
                        ic_data  <= word_all;
                    end
                    LOAD: begin
                        lsb_done  <= 1'b1;
                        lsb_busy  <= 1'b0;
                        lsb_rdata <= ld_word;
                    end
                    STORE: begin
                        lsb_done <= 1'b1;
                        lsb_busy <= 1'b0;
                        mem_wr   <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomised bench for mem_ctrl: a behavioural RAM image predicts every
// fetch word, load result and store effect, plus a few literal anchors.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ic_asking;
    logic [31:0] ic_addr;
    logic        flush;
    logic [31:0] ic_data;
    logic        ic_ready;
    logic        lsb_valid;
    logic        lsb_we;
    logic [31:0] lsb_addr;
    logic [1:0]  lsb_size;
    logic        lsb_signed;
    logic [31:0] lsb_wdata;
    logic [31:0] lsb_rdata;
    logic        lsb_done;
    logic        lsb_busy;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_asking(ic_asking), .ic_addr(ic_addr), .flush(flush),
        .ic_data(ic_data), .ic_ready(ic_ready),
        .lsb_valid(lsb_valid), .lsb_we(lsb_we), .lsb_addr(lsb_addr),
        .lsb_size(lsb_size), .lsb_signed(lsb_signed), .lsb_wdata(lsb_wdata),
        .lsb_rdata(lsb_rdata), .lsb_done(lsb_done), .lsb_busy(lsb_busy),
        .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din)
    );

    // Environment RAM (seen by the DUT) and reference image (model only).
    logic [7:0] ram  [0:4095];
    logic [7:0] mref [0:4095];

    assign mem_din = ram[mem_a[11:0]];

    always @(posedge clk) if (mem_wr) ram[mem_a[11:0]] <= mem_dout;

    typedef struct {bit st; logic [31:0] v;} lexp_t;

    logic [31:0] icq [$];
    lexp_t       lsq [$];
    bit          st_active = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          lat_ic, lat_ls;
    logic [31:0] tr [0:15];
    lexp_t       ce;
    logic [31:0] cw;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic int nsz(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] mload(input logic [31:0] a, input int n,
                                          input bit sg);
        logic [63:0] v = 0;
        logic [31:0] ai;
        for (int i = 0; i < n; i++) begin
            ai = a + 32'(i);
            v  = v | (64'(mref[ai[11:0]]) << (8 * i));
        end
        if (sg && v[8*n-1]) v = v - (64'd1 << (8 * n));
        return v[31:0];
    endfunction

    task automatic mstore(input logic [31:0] a, input int n,
                          input logic [31:0] wd);
        logic [31:0] ai;
        for (int i = 0; i < n; i++) begin
            ai = a + 32'(i);
            mref[ai[11:0]] = 8'(wd >> (8 * i));
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] b);
        ram[a[11:0]]  = b;
        mref[a[11:0]] = b;
    endtask

    always @(negedge clk) begin
        if (ic_ready) begin
            if (icq.size() == 0) chk("ic_ready_unexpected", 32'(ic_ready), 0);
            else begin
                cw = icq.pop_front();
                chk("ic_data", ic_data, cw);
            end
        end
        if (lsb_done) begin
            if (lsq.size() == 0) chk("lsb_done_unexpected", 32'(lsb_done), 0);
            else begin
                ce = lsq.pop_front();
                if (!ce.st) chk("lsb_rdata", lsb_rdata, ce.v);
            end
        end
        if (mem_wr) chk("mem_wr_outside_store", 32'(st_active), 1);
    end

    task automatic run_op(input bit dic, input logic [31:0] ia,
                          input bit dls, input bit we, input logic [31:0] la,
                          input logic [1:0] sz, input bit sg,
                          input logic [31:0] wd, input int fl_k, input bit fa,
                          input logic [31:0] ia2, input bit bz);
        int n_ic = 0, n_ls = 0, s_ic = 0, s_ls = 0;
        lat_ic = -1;
        lat_ls = -1;
        if (dls) begin
            n_ls = 1;
            if (we) begin
                mstore(la, nsz(sz), wd);
                lsq.push_back('{1'b1, 32'h0});
                st_active = 1'b1;
            end else lsq.push_back('{1'b0, mload(la, nsz(sz), sg)});
        end
        if (dic && fl_k < 0) begin
            icq.push_back(mload(ia, 4, 1'b0));
            n_ic++;
        end
        if (fl_k >= 0 && fa) begin
            icq.push_back(mload(ia2, 4, 1'b0));
            n_ic++;
        end
        @(posedge clk); #1;
        ic_asking = dic; ic_addr = ia;
        lsb_valid = dls; lsb_we = we; lsb_addr = la;
        lsb_size = sz; lsb_signed = sg; lsb_wdata = wd;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                ic_asking = 1'b0;
                lsb_valid = 1'b0;
                if (bz) begin
                    lsb_valid = 1'b1; lsb_we = 1'b0;
                    lsb_addr = $urandom; lsb_size = 2'b00;
                end
            end
            if (k == 1 && bz) lsb_valid = 1'b0;
            if (k == fl_k) begin flush = 1'b0; ic_asking = 1'b0; end
            if (k + 1 == fl_k) begin
                flush = 1'b1;
                if (fa) begin ic_asking = 1'b1; ic_addr = ia2; end
            end
            if (k < 16) tr[k] = mem_a;
            if (ic_ready) begin s_ic++; lat_ic = k; end
            if (lsb_done) begin s_ls++; lat_ls = k; end
            if (s_ic >= n_ic && s_ls >= n_ls && k >= 6) break;
        end
        if (s_ic < n_ic || s_ls < n_ls) begin
            chk("op_timeout", 32'(s_ic + s_ls), 32'(n_ic + n_ls));
            icq.delete();
            lsq.delete();
        end
        @(negedge clk); #1;
        st_active = 1'b0;
    endtask

    logic [31:0] ra, rw;
    int          kind, n, mm;

    initial begin
        rst_n = 1'b0; ic_asking = 1'b0; ic_addr = '0; flush = 1'b0;
        lsb_valid = 1'b0; lsb_we = 1'b0; lsb_addr = '0; lsb_size = 2'b00;
        lsb_signed = 1'b0; lsb_wdata = '0;
        for (int i = 0; i < 4096; i++) begin
            ram[i]  = 8'($urandom);
            mref[i] = ram[i];
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ic_data", ic_data, 0);
        chk("rst_pulses", {29'b0, ic_ready, lsb_done, mem_wr}, 0);
        chk("rst_lsb_rdata", lsb_rdata, 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_busy_dout", {23'b0, lsb_busy, mem_dout}, 0);
        rst_n = 1'b1;

        // Reset in the middle of a store.
        st_active = 1'b1;
        @(posedge clk); #1;
        lsb_valid = 1'b1; lsb_we = 1'b1; lsb_addr = 32'h700;
        lsb_size = 2'b10; lsb_wdata = 32'h11223344;
        @(posedge clk); #1;
        lsb_valid = 1'b0;
        chk("store_wr_high", 32'(mem_wr), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_wr_same_edge", 32'(mem_wr), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_mid_outputs",
            {29'b0, ic_ready, lsb_done, mem_wr} | mem_a | {24'b0, mem_dout}, 0);
        chk("rst_mid_busy", 32'(lsb_busy), 0);
        st_active = 1'b0;
        for (int i = 0; i < 4; i++) ram[12'h700 + i] = mref[12'h700 + i];

        // Fetch word from 0x100.
        poke(32'h100, 8'h13); poke(32'h101, 8'h05);
        poke(32'h102, 8'h00); poke(32'h103, 8'h00);
        run_op(1, 32'h100, 0, 0, 0, 0, 0, 0, -1, 0, 0, 0);
        for (int i = 0; i < 4; i++) chk("fetch_addr", tr[i], 32'h100 + 32'(i));
        chk("fetch_lat", 32'(lat_ic), 4);
        chk("fetch_word", ic_data, 32'h00000513);

        // Signed byte and unsigned half loads.
        poke(32'h200, 8'h80);
        run_op(0, 0, 1, 0, 32'h200, 2'b00, 1, 0, -1, 0, 0, 0);
        chk("load_sb", lsb_rdata, 32'hFFFFFF80);
        poke(32'h202, 8'h01); poke(32'h203, 8'h80);
        run_op(0, 0, 1, 0, 32'h202, 2'b01, 0, 0, -1, 0, 0, 0);
        chk("load_hu", lsb_rdata, 32'h00008001);
        chk("load_hu_lat", 32'(lat_ls), 2);

        // Store word, then fetch across the top of the address space.
        run_op(0, 0, 1, 1, 32'h300, 2'b10, 0, 32'hDEADBEEF, -1, 0, 0, 0);
        chk("store_bytes",
            {ram[12'h303], ram[12'h302], ram[12'h301], ram[12'h300]},
            32'hDEADBEEF);
        chk("store_lat", 32'(lat_ls), 4);
        run_op(1, 32'hFFFFFFFE, 0, 0, 0, 0, 0, 0, -1, 0, 0, 0);
        chk("wrap_a0", tr[0], 32'hFFFFFFFE);
        chk("wrap_a1", tr[1], 32'hFFFFFFFF);
        chk("wrap_a2", tr[2], 32'h00000000);
        chk("wrap_a3", tr[3], 32'h00000001);

        // Simultaneous fetch and load; extra lsb_valid while busy.
        run_op(1, 32'h40, 1, 0, 32'h80, 2'b10, 0, 0, -1, 0, 0, 1);
        chk("arb_load_lat", 32'(lat_ls), 4);
        chk("arb_fetch_lat", 32'(lat_ic), 9);

        // Flush a fetch mid-way with a new request on the same edge.
        poke(32'h500, 8'hAA); poke(32'h600, 8'h55);
        run_op(1, 32'h500, 0, 0, 0, 0, 0, 0, 3, 1, 32'h600, 0);
        chk("flush_refetch_lat", 32'(lat_ic), 8);

        for (int t = 0; t < 200; t++) begin
            kind = $urandom_range(4, 0);
            ra   = $urandom;
            rw   = $urandom;
            case (kind)
                0: begin
                    run_op(1, ra, 0, 0, 0, 0, 0, 0, -1, 0, 0, 0);
                    chk("rnd_fetch_lat", 32'(lat_ic), 4);
                    for (int i = 0; i < 4; i++)
                        chk("rnd_fetch_addr", tr[i], ra + 32'(i));
                end
                1, 2: begin
                    lsb_size = 2'($urandom);
                    n = nsz(lsb_size);
                    run_op(0, 0, 1, kind == 2, ra, lsb_size, 1'($urandom),
                           rw, -1, 0, 0, kind == 1);
                    chk("rnd_lsb_lat", 32'(lat_ls), 32'(n));
                    for (int i = 0; i < n; i++)
                        chk("rnd_lsb_addr", tr[i], ra + 32'(i));
                end
                3: run_op(1, $urandom, 1, 1'($urandom), ra, 2'($urandom),
                          1'($urandom), rw, -1, 0, 0, 0);
                default:
                    run_op(1, ra, 0, 0, 0, 0, 0, 0, $urandom_range(4, 1),
                           1'($urandom), rw, 0);
            endcase
        end

        mm = 0;
        for (int i = 0; i < 4096; i++) if (ram[i] !== mref[i]) mm++;
        chk("ram_image_mismatches", 32'(mm), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
